// File: rtl/pong_pkg.sv
// pong_pkg: shared game states, direction encodings and default matrix size.
package pong_pkg;
  typedef enum logic [1:0] {IDLE, RUN, SCORED} state_e;
  localparam logic DIR_LEFT    = 1'b0;
  localparam logic DIR_RIGHT   = 1'b1;
  localparam logic DIR_UP      = 1'b0;
  localparam logic DIR_DOWN    = 1'b1;
  localparam int   MATRIX_COLS = 16;
  localparam int   MATRIX_ROWS = 16;
endpackage

// File: rtl/ball_engine_tick_gen.sv
// tick_gen: modulo-TICK_DIV counter with synchronous clear; tick marks the last count.
module tick_gen #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick  = cnt_q == CW'(TICK_DIV - 1);
  assign cnt_d = (clr || tick) ? '0 : cnt_q + CW'(1);
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/ball_engine.sv
// ball_engine: serves the ball from the centre, steps it per tick, bounces it off walls and paddles, flags misses.
module ball_engine
  import pong_pkg::*;
#(
  parameter int  COLS       = MATRIX_COLS,
  parameter int  ROWS       = MATRIX_ROWS,
  parameter int  PADDLE_LEN = 3,
  parameter int  TICK_DIV   = 25_000_000,
  localparam int XW         = $clog2(COLS),
  localparam int YW         = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          serve_dir,
  input  logic [YW-1:0] p1_y,
  input  logic [YW-1:0] p2_y,
  output logic [XW-1:0] b_x,
  output logic [YW-1:0] b_y,
  output logic          busy,
  output logic          p1_point,
  output logic          p2_point
);
  localparam logic [XW-1:0] X_MID = XW'(COLS / 2);
  localparam logic [YW-1:0] Y_MID = YW'(ROWS / 2);
  localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);
  localparam logic [YW:0]   P_EXT = (YW + 1)'(PADDLE_LEN - 1);
  state_e        state_q, state_d;
  logic [XW-1:0] bx_q, bx_d;
  logic [YW-1:0] by_q, by_d;
  logic          dx_q, dx_d, dy_q, dy_d;
  logic          p1_q, p1_d, p2_q, p2_d;
  logic          clr, tick, at_p1, at_p2, hit1, hit2, hit, y_edge;
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .tick(tick)
  );
  assign at_p1  = dx_q == DIR_LEFT && bx_q == XW'(1);
  assign at_p2  = dx_q == DIR_RIGHT && bx_q == X_MAX - XW'(1);
  // Paddle span top is widened by one bit so a paddle near the bottom is not wrapped.
  assign hit1   = by_q >= p1_y && {1'b0, by_q} <= {1'b0, p1_y} + P_EXT;
  assign hit2   = by_q >= p2_y && {1'b0, by_q} <= {1'b0, p2_y} + P_EXT;
  assign hit    = at_p1 ? hit1 : hit2;
  assign y_edge = dy_q == DIR_UP ? by_q == '0 : by_q == Y_MAX;
  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    by_d    = by_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    p1_d    = 1'b0;
    p2_d    = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        bx_d = X_MID;
        by_d = Y_MID;
        if (start) begin
          dx_d    = serve_dir;
          dy_d    = DIR_DOWN;
          clr     = 1'b1;
          state_d = RUN;
        end
      end
      RUN: if (tick) begin
        dy_d = y_edge ? ~dy_q : dy_q;
        by_d = (dy_q == DIR_DOWN) ^ y_edge ? by_q + YW'(1) : by_q - YW'(1);
        if (at_p1 || at_p2) begin
          dx_d    = hit ? ~dx_q : dx_q;
          bx_d    = hit ? (at_p1 ? XW'(2) : X_MAX - XW'(2)) : (at_p1 ? '0 : X_MAX);
          p2_d    = !hit && at_p1;
          p1_d    = !hit && at_p2;
          state_d = hit ? RUN : SCORED;
        end else begin
          bx_d = dx_q == DIR_RIGHT ? bx_q + XW'(1) : bx_q - XW'(1);
        end
      end
      SCORED: if (tick) begin
        bx_d    = X_MID;
        by_d    = Y_MID;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bx_q    <= X_MID;
      by_q    <= Y_MID;
      dx_q    <= 1'b0;
      dy_q    <= DIR_DOWN;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
    end
  end
  assign b_x      = bx_q;
  assign b_y      = by_q;
  assign busy     = state_q != IDLE;
  assign p1_point = p1_q;
  assign p2_point = p2_q;
endmodule

// File: doc/ball_engine.md
# ball_engine

Game-play stage directly downstream of `init`. Once `init` has reset the field, `ball_engine` launches the ball from the centre of the LED matrix and steps it one cell per game tick. It reflects the ball off the top and bottom walls and off the paddles, and it detects misses. The ball position and one-cycle point pulses are consumed by the scoreboard and the matrix renderer.

## Interface
Parameters:
- `COLS`, default 16: matrix width. Paddle 1 is in column 0; paddle 2 is in column `COLS-1`.
- `ROWS`, default 16: matrix height. Row 0 is the top row.
- `PADDLE_LEN`, default 3: paddle height in rows.
- `TICK_DIV`, default 25_000_000: clock cycles per game tick. Must be ≥ 2.
- Derived widths: `XW = $clog2(COLS)`, `YW = $clog2(ROWS)`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: serve request. Honoured only in IDLE.
- `serve_dir` in 1: sampled with `start`. 0 = serve toward paddle 1 (x decreasing); 1 = serve toward paddle 2.
- `p1_y` in YW: top row of paddle 1.
- `p2_y` in YW: top row of paddle 2.
- `b_x` out XW: ball column. Registered.
- `b_y` out YW: ball row. Registered.
- `busy` out 1: high in RUN and SCORED.
- `p1_point` out 1: one-cycle pulse; paddle 1's player scored.
- `p2_point` out 1: one-cycle pulse; paddle 2's player scored.

## Operation
- **Reset:** state IDLE; `b_x = COLS/2`, `b_y = ROWS/2`; `dx = 0`, `dy = down`; tick counter = 0; `busy`, `p1_point`, `p2_point` all 0. `rst` overrides `start` in the same cycle.
- **IDLE:**
  - Ball held at centre.
  - On `start`: set `dx = serve_dir`, `dy = down` (y increasing), clear the counter, go to RUN.
- **RUN:**
  - The counter counts 0..`TICK_DIV-1`. The cycle where it equals `TICK_DIV-1` is a step cycle; the counter then wraps to 0.
  - `start` is ignored.
- **Vertical step:**
  - `dy = up` and `b_y = 0` → `dy` becomes down, `b_y` becomes 1.
  - `dy = down` and `b_y = ROWS-1` → `dy` becomes up, `b_y` becomes `ROWS-2`.
  - Otherwise `b_y ± 1`.
- **Horizontal step:**
  - Moving left with `b_x = 1` → paddle-1 check.
  - Moving right with `b_x = COLS-2` → paddle-2 check.
  - Otherwise `b_x ± 1`.
- **Paddle check:**
  - Uses the pre-step `b_y`.
  - Hit when `p_y ≤ b_y ≤ p_y + PADDLE_LEN - 1`. The upper bound is computed at YW+1 bits, with no clamping.
  - Hit → flip `dx` and move one cell away from the paddle (column 2, or `COLS-3`).
  - Miss → `b_x` moves into the paddle column (0 or `COLS-1`). The opponent's point pulse fires in the same cycle the position updates (miss at column 0 → `p2_point`; miss at `COLS-1` → `p1_point`). Go to SCORED.
  - The vertical step still applies on hit and miss cycles, including corner cases.
- **SCORED:**
  - Ball frozen at the miss position for exactly one tick (`TICK_DIV` cycles).
  - Then go to IDLE with the ball recentred.
  - Point pulses never repeat.
- **Reset mid-operation:** returns to IDLE and recentres the ball. No point pulse is produced.

## Timing
- All outputs are registered. A step computed in the step cycle is visible on the following clock edge.
- The first step after `start` occurs `TICK_DIV` cycles after the `start` cycle.
- `busy` rises the cycle after `start` is accepted and falls the cycle the ball is recentred.
- The point pulse lasts one cycle, aligned with `b_x` showing the paddle column.
- Paddle inputs are sampled only in step cycles. They may change at any time.

## Structure
- Shared package `pong_pkg` holds:
  - the state enum `IDLE`/`RUN`/`SCORED`;
  - direction constants `DIR_LEFT`/`DIR_RIGHT`/`DIR_UP`/`DIR_DOWN`;
  - the default matrix dimensions, shared with `init` and the renderer.
- One sub-module: `tick_gen`, a modulo-`TICK_DIV` counter with synchronous clear, producing a one-cycle `tick` output.
- The FSM and step datapath live in `ball_engine`.

## Test plan
All scenarios use `COLS=16`, `ROWS=8`, `PADDLE_LEN=3`, `TICK_DIV=4`.

1. Reset for 2 cycles → `b_x=8`, `b_y=4`, `busy=0`, both point outputs 0.
2. `start=1`, `serve_dir=1` → `busy=1` the next cycle; 4 cycles after `start`, `b_x=9`, `b_y=5`; 4 cycles later, `b_x=10`, `b_y=6`.
3. Ball at `b_y=7` moving down → next step gives `b_y=6` and `dy` up. Ball at `b_y=0` moving up → next step gives `b_y=1`.
4. Ball at `b_x=1`, `b_y=3`, moving left, `p1_y=2` → next step gives `b_x=2` moving right; no point pulse.
5. Same setup with `p1_y=5` → next step gives `b_x=0` and `p2_point=1` for exactly one cycle. The ball holds for 4 cycles, then `b_x=8`, `b_y=4`, `busy=0`.
6. Assert `rst` during RUN, one cycle before a step → next cycle IDLE at centre, no pulses. Also: `start` pulsed while `busy=1` has no effect on the trajectory.
